banked_register_file: RTL and testbench

- Next-generation ARM register file with per-mode banked registers (FIQ: r8–r14; IRQ/SVC/ABT/UND: r13–r14), a per-mode SPSR, and two write ports (ALU result and load/base writeback).
- Parametrised read-port count, optional write-to-read bypass, and a PC step that auto-increments every cycle.
- Single-cycle atomic exception entry: saves CPSR into the SPSR, saves the PC into the banked LR, switches mode and loads the vector.
- Sits between decode (operand reads) and writeback in the CPU top level.

---
 rtl/banked_register_file.sv | 150 +++++++++++++++
 tb/tb_banked_register_file.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_register_file.sv
// Banked ARM-style register file: per-mode r8-r14 / r13-r14 banks,
// per-mode SPSR, two write ports, auto-stepping PC, atomic exception entry.
module banked_register_file #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_READ_PORTS = 3,
  parameter int PC_INDEX       = 15,
  parameter int PC_STEP        = 4,
  parameter int RESET_PC       = 0,
  parameter int BYPASS         = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*WORD_SIZE-1:0]  rd_data,
  input  logic                               user_bank,
  input  logic                               wr0_en,
  input  logic [ADDR_WIDTH-1:0]              wr0_addr,
  input  logic [WORD_SIZE-1:0]               wr0_data,
  input  logic                               wr1_en,
  input  logic [ADDR_WIDTH-1:0]              wr1_addr,
  input  logic [WORD_SIZE-1:0]               wr1_data,
  input  logic                               pc_we,
  input  logic [WORD_SIZE-1:0]               pc_in,
  output logic [WORD_SIZE-1:0]               pc_out,
  input  logic                               cpsr_we,
  input  logic [WORD_SIZE-1:0]               cpsr_in,
  output logic [WORD_SIZE-1:0]               cpsr_out,
  input  logic                               spsr_we,
  input  logic [WORD_SIZE-1:0]               spsr_in,
  output logic [WORD_SIZE-1:0]               spsr_out,
  input  logic                               exc_req,
  input  logic [4:0]                         exc_mode,
  input  logic [WORD_SIZE-1:0]               exc_vector
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0]  word_t;

  localparam int    NPHYS = 32;
  localparam addr_t PC_A  = addr_t'(PC_INDEX);

  localparam logic [2:0] MI_USR = 3'd0;
  localparam logic [2:0] MI_FIQ = 3'd1;
  localparam logic [2:0] MI_IRQ = 3'd2;

  function automatic logic [2:0] mode_idx(input logic [4:0] m);
    case (m)
      5'b10001: return 3'd1;
      5'b10010: return 3'd2;
      5'b10011: return 3'd3;
      5'b10111: return 3'd4;
      5'b11011: return 3'd5;
      default:  return MI_USR;
    endcase
  endfunction

  // 0-15 shared, 16-22 FIQ r8-r14, then r13/r14 pairs for IRQ,SVC,ABT,UND
  function automatic logic [4:0] phys(input logic [2:0] mi, input addr_t a);
    logic [4:0] p;
    p = 5'(a);
    if (mi == MI_FIQ && a >= addr_t'(8) && a <= addr_t'(14))
      p = 5'(a) + 5'd8;
    else if (mi >= MI_IRQ && (a == addr_t'(13) || a == addr_t'(14)))
      p = 5'd23 + 5'({mi - 3'd2, 1'b0}) + 5'(a == addr_t'(14));
    return p;
  endfunction

  word_t regs_q [NPHYS];
  word_t regs_d [NPHYS];
  word_t spsr_q [6];
  word_t spsr_d [6];
  word_t pc_q, pc_d;
  word_t cpsr_q, cpsr_d;

  logic [2:0] cur_mi, eff_mi, exc_mi;
  logic       exc_go;

  assign cur_mi = mode_idx(cpsr_q[4:0]);
  assign eff_mi = user_bank ? MI_USR : cur_mi;
  assign exc_mi = mode_idx(exc_mode);
  assign exc_go = exc_req && (exc_mi != MI_USR);

  always_comb begin
    regs_d = regs_q;
    if (wr1_en && wr1_addr != PC_A)
      regs_d[phys(eff_mi, wr1_addr)] = wr1_data;
    if (wr0_en && wr0_addr != PC_A)
      regs_d[phys(eff_mi, wr0_addr)] = wr0_data;
    if (exc_go)
      regs_d[phys(exc_mi, addr_t'(14))] = pc_q;
  end

  always_comb begin
    spsr_d = spsr_q;
    if (exc_go)
      spsr_d[exc_mi] = cpsr_q;
    else if (spsr_we && cur_mi != MI_USR)
      spsr_d[cur_mi] = spsr_in;
  end

  always_comb begin
    cpsr_d = cpsr_q;
    if (exc_go) begin
      cpsr_d[4:0] = exc_mode;
      cpsr_d[7]   = 1'b1;
      if (exc_mi == MI_FIQ) cpsr_d[6] = 1'b1;
    end else if (cpsr_we) begin
      cpsr_d = cpsr_in;
    end
  end

  always_comb begin
    pc_d = pc_q + word_t'(PC_STEP);
    if (exc_go)     pc_d = exc_vector;
    else if (pc_we) pc_d = pc_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
      for (int i = 0; i < 6; i++)     spsr_q[i] <= '0;
      pc_q   <= word_t'(RESET_PC);
      cpsr_q <= word_t'(8'hD3);
    end else begin
      regs_q <= regs_d;
      spsr_q <= spsr_d;
      pc_q   <= pc_d;
      cpsr_q <= cpsr_d;
    end
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
    addr_t a;
    word_t v;
    assign a = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    always_comb begin
      v = regs_q[phys(eff_mi, a)];
      if (BYPASS != 0 && wr1_en && wr1_addr == a) v = wr1_data;
      if (BYPASS != 0 && wr0_en && wr0_addr == a) v = wr0_data;
      if (a == PC_A) v = pc_q;
    end
    assign rd_data[k*WORD_SIZE +: WORD_SIZE] = v;
  end

  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;
  assign spsr_out = (cur_mi == MI_USR) ? '0 : spsr_q[cur_mi];

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        user_bank;
  logic        wr0_en, wr1_en;
  logic [3:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        pc_we, cpsr_we, spsr_we, exc_req;
  logic [31:0] pc_in, cpsr_in, spsr_in, exc_vector;
  logic [31:0] pc_out, cpsr_out, spsr_out;
  logic [4:0]  exc_mode;
  logic        done = 1'b0;

  banked_register_file dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .user_bank(user_bank),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .pc_we(pc_we), .pc_in(pc_in), .pc_out(pc_out),
    .cpsr_we(cpsr_we), .cpsr_in(cpsr_in), .cpsr_out(cpsr_out),
    .spsr_we(spsr_we), .spsr_in(spsr_in), .spsr_out(spsr_out),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  port;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  string       nm[$];
  exp_t        me;
  string       mn;
  logic [31:0] mact;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] old_pc;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me = sb.pop_front();
      mn = nm.pop_front();
      case (me.sel)
        2'd0:    mact = pc_out;
        2'd1:    mact = cpsr_out;
        2'd2:    mact = spsr_out;
        default: mact = rd_data[me.port*32 +: 32];
      endcase
      checks++;
      if (mact !== me.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mn, mact, me.v);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] ex,
                     input string n);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, ex);
    end
  endtask

  task automatic push(input int sel, input int port,
                      input logic [31:0] v, input string n);
    exp_t e;
    e.sel  = 2'(sel);
    e.port = 8'(port);
    e.v    = v;
    sb.push_back(e);
    nm.push_back(n);
  endtask

  task automatic rd(input int k, input logic [3:0] a,
                    input logic [31:0] v, input string n);
    rd_addr[k*4 +: 4] = a;
    push(3, k, v, n);
  endtask

  task cyc;
    if (pc_we) exp_pc = pc_in;
    else       exp_pc = exp_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task clr;
    wr0_en = 0; wr1_en = 0; pc_we = 0;
    cpsr_we = 0; spsr_we = 0; exc_req = 0;
  endtask

  initial begin
    reset = 1; rd_addr = '0; user_bank = 0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    pc_in = '0; cpsr_in = '0; spsr_in = '0;
    exc_mode = '0; exc_vector = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk(pc_out, 32'h0, "in_rst_pc");
    chk(cpsr_out, 32'hD3, "in_rst_cpsr");
    chk(spsr_out, 32'h0, "in_rst_spsr");
    chk(rd_data[31:0], 32'h0, "in_rst_r0");
    reset = 0;
    exp_pc = 32'h0;
    push(0, 0, exp_pc, "rst_pc");
    push(1, 0, 32'hD3, "rst_cpsr");
    push(2, 0, 32'h0, "rst_spsr");
    rd(0, 4'd0, 32'h0, "rst_r0");
    rd(1, 4'd7, 32'h0, "rst_r7");
    rd(2, 4'd13, 32'h0, "rst_r13");
    for (int i = 1; i <= 3; i++) begin
      cyc();
      push(0, 0, exp_pc, "idle_pc");
    end
    wr0_en = 1; wr0_addr = 4'd13; wr0_data = 32'hAAAA;
    rd(0, 4'd13, 32'hAAAA, "byp_svc_r13");
    cyc();
    wr0_en = 0; cpsr_we = 1; cpsr_in = 32'h10;
    rd(0, 4'd13, 32'hAAAA, "svc_r13");
    cyc();
    cpsr_we = 0;
    wr0_en = 1; wr0_addr = 4'd13; wr0_data = 32'h5555;
    spsr_we = 1; spsr_in = 32'hDEAD;
    push(1, 0, 32'h10, "cpsr_usr");
    push(2, 0, 32'h0, "spsr_usr_zero");
    cyc();
    clr(); cpsr_we = 1; cpsr_in = 32'h13;
    rd(0, 4'd13, 32'h5555, "usr_r13");
    cyc();
    clr();
    push(1, 0, 32'h13, "cpsr_svc");
    rd(0, 4'd13, 32'hAAAA, "svc_r13_back");
    push(2, 0, 32'h0, "spsr_usr_we_ignored");
    cyc();
    user_bank = 1;
    rd(0, 4'd13, 32'h5555, "user_bank_r13");
    cyc();
    user_bank = 0; spsr_we = 1; spsr_in = 32'h1234;
    cyc();
    clr();
    push(2, 0, 32'h1234, "spsr_svc");
    wr0_en = 1; wr0_addr = 4'd3; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 4'd3; wr1_data = 32'h22;
    rd(1, 4'd3, 32'h11, "byp_dual");
    cyc();
    clr();
    rd(1, 4'd3, 32'h11, "dual_stored");
    wr1_en = 1; wr1_addr = 4'd4; wr1_data = 32'h44;
    rd(2, 4'd4, 32'h44, "byp_wr1");
    cyc();
    clr();
    rd(2, 4'd4, 32'h44, "wr1_stored");
    wr0_en = 1; wr0_addr = 4'd15; wr0_data = 32'hFFFF_0000;
    push(0, 0, exp_pc, "pc_before_r15");
    rd(0, 4'd15, exp_pc, "rd_r15_is_pc");
    cyc();
    clr();
    push(0, 0, exp_pc, "pc_after_r15");
    cpsr_we = 1; cpsr_in = 32'h6000_0010;
    pc_we = 1; pc_in = 32'h100;
    wr1_en = 1; wr1_addr = 4'd8; wr1_data = 32'h88;
    cyc();
    clr();
    push(0, 0, 32'h100, "pc_0x100");
    push(1, 0, 32'h6000_0010, "cpsr_usr_flags");
    exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C;
    cyc();
    exp_pc = 32'h1C;
    clr();
    push(0, 0, 32'h1C, "fiq_pc");
    push(1, 0, 32'h6000_00D1, "fiq_cpsr");
    push(2, 0, 32'h6000_0010, "fiq_spsr");
    rd(0, 4'd14, 32'h100, "fiq_lr");
    rd(1, 4'd8, 32'h0, "fiq_r8");
    cyc();
    user_bank = 1;
    rd(1, 4'd8, 32'h88, "usr_r8_kept");
    rd(0, 4'd14, 32'h0, "usr_r14");
    cyc();
    user_bank = 0;
    exc_req = 1; exc_mode = 5'b10000; exc_vector = 32'h999;
    cyc();
    clr();
    push(0, 0, exp_pc, "exc_usr_ignored_pc");
    push(1, 0, 32'h6000_00D1, "exc_usr_ignored_cpsr");
    old_pc = exp_pc;
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18;
    pc_we = 1; pc_in = 32'h500;
    cpsr_we = 1; cpsr_in = 32'h1F;
    spsr_we = 1; spsr_in = 32'h7777;
    wr0_en = 1; wr0_addr = 4'd14; wr0_data = 32'hBAD;
    cyc();
    exp_pc = 32'h18;
    clr();
    push(0, 0, 32'h18, "irq_pc_wins");
    push(1, 0, 32'h6000_00D2, "irq_cpsr_wins");
    push(2, 0, 32'h6000_00D1, "irq_spsr");
    rd(0, 4'd14, old_pc, "irq_lr");
    cyc();
    old_pc = exp_pc;
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18;
    wr0_en = 1; wr0_addr = 4'd14; wr0_data = 32'hBAD;
    cyc();
    exp_pc = 32'h18;
    clr();
    rd(0, 4'd14, old_pc, "lr_over_port");
    push(2, 0, 32'h6000_00D2, "spsr_irq_reentry");
    cpsr_we = 1; cpsr_in = 32'h6000_00D1;
    cyc();
    clr();
    rd(0, 4'd14, 32'hBAD, "fiq_r14_old_bank");
    push(2, 0, 32'h6000_0010, "fiq_spsr_kept");
    cyc();
    reset = 1;
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18;
    rd_addr[3:0] = 4'd13;
    #1;
    chk(pc_out, 32'h0, "arst_now_pc");
    chk(cpsr_out, 32'hD3, "arst_now_cpsr");
    chk(spsr_out, 32'h0, "arst_now_spsr");
    chk(rd_data[31:0], 32'h0, "arst_now_r13");
    push(0, 0, 32'h0, "arst_pc");
    push(1, 0, 32'hD3, "arst_cpsr");
    push(2, 0, 32'h0, "arst_spsr");
    rd(0, 4'd13, 32'h0, "arst_r13");
    rd(1, 4'd3, 32'h0, "arst_r3");
    rd(2, 4'd4, 32'h0, "arst_r4");
    @(posedge clk);
    #1;
    reset = 0;
    clr();
    exp_pc = 32'h0;
    user_bank = 1;
    push(0, 0, 32'h0, "post_rst_pc");
    push(1, 0, 32'hD3, "post_rst_cpsr");
    rd(0, 4'd13, 32'h0, "post_rst_usr_r13");
    rd(1, 4'd8, 32'h0, "post_rst_usr_r8");
    cyc();
    user_bank = 0;
    push(0, 0, exp_pc, "post_rst_pc_step");
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
